// File: rtl/loopback_fifo_mc_pkg.sv
// loopback_fifo_mc_pkg
//    Shared definitions for the multi-channel loopback FIFO: Avalon register
//    offsets, STATUS/CTRL bit positions, the DMA request FSM state type and
//    the FIFO level-width helper.
package loopback_fifo_mc_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int unsigned ST_EMPTY = 16;
   localparam int unsigned ST_FULL  = 17;
   localparam int unsigned ST_OVF   = 18;
   localparam int unsigned ST_UDF   = 19;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_IEN    = 1;
   localparam int unsigned CTRL_CLR    = 2;
   localparam int unsigned CTRL_ERRCLR = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } req_state_e;

   // Level must represent 0..DEPTH inclusive.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/loopback_fifo_chan.sv
// loopback_fifo_chan
//    One loopback channel: FIFO storage, CTRL/flag registers and the TX/RX
//    DMA peripheral-request FSMs.
// Ports:
//    clk, reset_n          clock, asynchronous active-low reset
//    push, pop             DATA write / DATA read strobes for this channel
//    ctrl_we               CTRL write strobe for this channel
//    wdata                 Avalon write data
//    rd_reg                register index being read
//    rd_word               combinational readback for rd_reg (DATA: head word)
//    tx_single/tx_burst    TX requests (free space), tx_ack acknowledge
//    rx_single/rx_burst    RX requests (held words), rx_ack acknowledge
//    err_irq               (ovf|udf) & ien, unregistered
module loopback_fifo_chan
   import loopback_fifo_mc_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic              ctrl_we,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        rd_reg,
   output logic [DATA_W-1:0] rd_word,
   output logic              tx_single,
   output logic              tx_burst,
   input  logic              tx_ack,
   output logic              rx_single,
   output logic              rx_burst,
   input  logic              rx_ack,
   output logic              err_irq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = level_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     level;
   logic              en, ien, ovf, udf;
   logic              empty, full, do_push, do_pop, clr, errclr;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign clr     = ctrl_we & wdata[CTRL_CLR];
   assign errclr  = ctrl_we & wdata[CTRL_ERRCLR];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign err_irq = (ovf | udf) & ien;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         en     <= 1'b0;
         ien    <= 1'b0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
         end
         if (ctrl_we) begin
            en  <= wdata[CTRL_EN];
            ien <= wdata[CTRL_IEN];
         end
         // A flag being set wins over a simultaneous errclr.
         if (push && full) ovf <= 1'b1;
         else if (errclr)  ovf <= 1'b0;
         if (pop && empty) udf <= 1'b1;
         else if (errclr)  udf <= 1'b0;
      end
   end

   always_comb begin
      rd_word = '0;
      case (rd_reg)
         REG_DATA: begin
            if (!empty) rd_word = mem[rd_ptr];
         end
         REG_STATUS: begin
            rd_word[LW-1:0] = level;
            rd_word[ST_EMPTY] = empty;
            rd_word[ST_FULL]  = full;
            rd_word[ST_OVF]   = ovf;
            rd_word[ST_UDF]   = udf;
         end
         REG_CTRL: begin
            rd_word[CTRL_EN]  = en;
            rd_word[CTRL_IEN] = ien;
         end
         default: ;
      endcase
   end

   // Request FSMs: index 0 = TX (free words), index 1 = RX (held words).
   // single/burst are captured on the IDLE->REQ transition and frozen for
   // the rest of the request.
   req_state_e    st_q [2];
   req_state_e    st_d [2];
   logic [1:0]    sgl_q, bst_q, sgl_d, bst_d, ack;
   logic [LW-1:0] avail [2];

   assign avail[0] = LW'(DEPTH) - level;
   assign avail[1] = level;
   assign ack      = {rx_ack, tx_ack};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned d = 0; d < 2; d++) st_q[d] <= IDLE;
         sgl_q <= '0;
         bst_q <= '0;
      end else begin
         for (int unsigned d = 0; d < 2; d++) st_q[d] <= st_d[d];
         sgl_q <= sgl_d;
         bst_q <= bst_d;
      end
   end

   always_comb begin
      sgl_d = sgl_q;
      bst_d = bst_q;
      for (int unsigned d = 0; d < 2; d++) begin
         st_d[d] = st_q[d];
         case (st_q[d])
            IDLE: begin
               sgl_d[d] = 1'b0;
               bst_d[d] = 1'b0;
               if (en && avail[d] != '0) begin
                  st_d[d]  = REQ;
                  sgl_d[d] = 1'b1;
                  bst_d[d] = (avail[d] >= LW'(BURST_LEN));
               end
            end
            REQ: begin
               if (ack[d]) begin
                  st_d[d]  = HOLD;
                  sgl_d[d] = 1'b0;
                  bst_d[d] = 1'b0;
               end else if (!en || clr) begin
                  st_d[d]  = IDLE;
                  sgl_d[d] = 1'b0;
                  bst_d[d] = 1'b0;
               end
            end
            HOLD: begin
               sgl_d[d] = 1'b0;
               bst_d[d] = 1'b0;
               if (!ack[d]) st_d[d] = IDLE;
            end
            default: begin
               st_d[d]  = IDLE;
               sgl_d[d] = 1'b0;
               bst_d[d] = 1'b0;
            end
         endcase
      end
   end

   assign tx_single = sgl_q[0];
   assign tx_burst  = bst_q[0];
   assign rx_single = sgl_q[1];
   assign rx_burst  = bst_q[1];

endmodule

// File: rtl/loopback_fifo_mc.sv
// loopback_fifo_mc
//    Multi-channel HPS DMA loopback FIFO with an Avalon-MM register slave.
// Ports:
//    clk, reset_n                 clock, asynchronous active-low reset
//    avs_address                  [AW-1:2] channel, [1:0] register
//    avs_write/avs_writedata      register write
//    avs_read/avs_readdata        register read, read latency 1
//    tx_pri_single/burst/ack      per-channel TX DMA request handshake
//    rx_pri_single/burst/ack      per-channel RX DMA request handshake
//    irq                          registered OR of per-channel (ovf|udf)&ien
module loopback_fifo_mc
   import loopback_fifo_mc_pkg::*;
#(
   parameter  int unsigned NCH       = 2,
   parameter  int unsigned DATA_W    = 32,
   parameter  int unsigned DEPTH     = 64,
   parameter  int unsigned BURST_LEN = 8,
   localparam int unsigned AW        = $clog2(NCH) + 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [AW-1:0]     avs_address,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   input  logic              avs_read,
   output logic [DATA_W-1:0] avs_readdata,
   output logic [NCH-1:0]    tx_pri_single,
   output logic [NCH-1:0]    tx_pri_burst,
   input  logic [NCH-1:0]    tx_pri_ack,
   output logic [NCH-1:0]    rx_pri_single,
   output logic [NCH-1:0]    rx_pri_burst,
   input  logic [NCH-1:0]    rx_pri_ack,
   output logic              irq
);

   logic [3:0]        ch_idx;
   logic [1:0]        reg_idx;
   logic [DATA_W-1:0] rd_word [NCH];
   logic [NCH-1:0]    err;
   logic [DATA_W-1:0] rd_mux;

   // Shift-then-cast keeps this valid when NCH=1 leaves no channel bits.
   assign ch_idx  = 4'(avs_address >> 2);
   assign reg_idx = avs_address[1:0];

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic sel;
      assign sel = (ch_idx == 4'(c));

      loopback_fifo_chan #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .BURST_LEN(BURST_LEN)
      ) u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .push     (avs_write & sel & (reg_idx == REG_DATA)),
         .pop      (avs_read  & sel & (reg_idx == REG_DATA)),
         .ctrl_we  (avs_write & sel & (reg_idx == REG_CTRL)),
         .wdata    (avs_writedata),
         .rd_reg   (reg_idx),
         .rd_word  (rd_word[c]),
         .tx_single(tx_pri_single[c]),
         .tx_burst (tx_pri_burst[c]),
         .tx_ack   (tx_pri_ack[c]),
         .rx_single(rx_pri_single[c]),
         .rx_burst (rx_pri_burst[c]),
         .rx_ack   (rx_pri_ack[c]),
         .err_irq  (err[c])
      );
   end

   // Unmatched channel indices fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (ch_idx == 4'(c)) rd_mux = rd_word[c];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avs_readdata <= '0;
         irq          <= 1'b0;
      end else begin
         avs_readdata <= avs_read ? rd_mux : '0;
         irq          <= |err;
      end
   end

endmodule

// File: tb/tb_loopback_fifo_mc.sv
// tb_loopback_fifo_mc
//    Self-checking bench for loopback_fifo_mc (NCH=2, DEPTH=64, BURST_LEN=8).
//    FIFO contents and flags are tracked with per-channel queues; request
//    handshakes are checked against fixed expected timings.
module tb_loopback_fifo_mc;

   localparam int unsigned NCH   = 2;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned BL    = 8;
   localparam int unsigned AW    = 3;

   logic           clk, reset_n;
   logic [AW-1:0]  avs_address;
   logic           avs_write, avs_read;
   logic [DW-1:0]  avs_writedata, avs_readdata;
   logic [NCH-1:0] tx_pri_single, tx_pri_burst, tx_pri_ack;
   logic [NCH-1:0] rx_pri_single, rx_pri_burst, rx_pri_ack;
   logic           irq;

   loopback_fifo_mc #(
      .NCH      (NCH),
      .DATA_W   (DW),
      .DEPTH    (DEPTH),
      .BURST_LEN(BL)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .avs_address  (avs_address),
      .avs_write    (avs_write),
      .avs_writedata(avs_writedata),
      .avs_read     (avs_read),
      .avs_readdata (avs_readdata),
      .tx_pri_single(tx_pri_single),
      .tx_pri_burst (tx_pri_burst),
      .tx_pri_ack   (tx_pri_ack),
      .rx_pri_single(rx_pri_single),
      .rx_pri_burst (rx_pri_burst),
      .rx_pri_ack   (rx_pri_ack),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mq [NCH][$];
   bit          m_ovf [NCH];
   bit          m_udf [NCH];
   bit          m_ien [NCH];

   function automatic logic [31:0] m_status(input int ch);
      logic [31:0] s;
      int lvl;
      lvl = mq[ch].size();
      s = '0;
      s[15:0] = 16'(lvl);
      s[16] = (lvl == 0);
      s[17] = (lvl == DEPTH);
      s[18] = m_ovf[ch];
      s[19] = m_udf[ch];
      return s;
   endfunction

   function automatic logic m_irq();
      logic r;
      r = 1'b0;
      for (int c = 0; c < NCH; c++) r |= (m_ovf[c] | m_udf[c]) & m_ien[c];
      return r;
   endfunction

   function automatic logic sig(input int sel);
      case (sel)
         0: return tx_pri_single[0];
         1: return tx_pri_burst[0];
         2: return rx_pri_single[0];
         3: return rx_pri_burst[0];
         4: return irq;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- bus tasks ----------------
   task automatic av_wr(input int ch, input int rg, input logic [31:0] d);
      @(negedge clk);
      avs_address   = AW'(ch * 4 + rg);
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic av_rd(input int ch, input int rg, output logic [31:0] d);
      @(negedge clk);
      avs_address = AW'(ch * 4 + rg);
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   task automatic push(input int ch, input logic [31:0] d);
      av_wr(ch, 0, d);
      if (mq[ch].size() == DEPTH) m_ovf[ch] = 1'b1;
      else mq[ch].push_back(d);
   endtask

   task automatic pop_chk(input int ch, input string tag);
      logic [31:0] got, exp;
      av_rd(ch, 0, got);
      if (mq[ch].size() == 0) begin
         exp = '0;
         m_udf[ch] = 1'b1;
      end else begin
         exp = mq[ch].pop_front();
      end
      chk(tag, got, exp);
   endtask

   task automatic status_chk(input int ch, input string tag);
      logic [31:0] got;
      av_rd(ch, 1, got);
      chk(tag, got, m_status(ch));
   endtask

   task automatic ctrl_wr(input int ch, input bit en, input bit ien, input bit clr, input bit errclr);
      av_wr(ch, 2, {28'd0, errclr, clr, ien, en});
      m_ien[ch] = ien;
      if (clr) mq[ch].delete();
      if (errclr) begin
         m_ovf[ch] = 1'b0;
         m_udf[ch] = 1'b0;
      end
   endtask

   task automatic wait_sig(input string tag, input int sel, input logic exp, input int maxcyc);
      for (int i = 0; i < maxcyc; i++) begin
         @(negedge clk);
         if (sig(sel) === exp) break;
      end
      chk(tag, sig(sel), exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int ch, op;

      reset_n = 1'b0;
      avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
      tx_pri_ack = '0; rx_pri_ack = '0;
      for (int c = 0; c < NCH; c++) begin
         m_ovf[c] = 0; m_udf[c] = 0; m_ien[c] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_reqs", {tx_pri_single, tx_pri_burst, rx_pri_single, rx_pri_burst}, 32'd0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_rdata", avs_readdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      av_rd(0, 1, got); chk("rst_status0", got, 32'h0001_0000);
      av_rd(0, 2, got); chk("rst_ctrl0", got, 32'd0);

      // TX request handshake
      ctrl_wr(0, 1, 0, 0, 0);
      wait_sig("tx_single_up", 0, 1'b1, 2);
      chk("tx_burst_up", tx_pri_burst[0], 1'b1);
      @(negedge clk); tx_pri_ack[0] = 1'b1;
      @(negedge clk); tx_pri_ack[0] = 1'b0;
      chk("tx_drop_single", tx_pri_single[0], 1'b0);
      chk("tx_drop_burst", tx_pri_burst[0], 1'b0);
      @(negedge clk);
      chk("tx_gap", tx_pri_single[0], 1'b0);
      wait_sig("tx_reassert", 0, 1'b1, 3);
      av_rd(0, 2, got); chk("ctrl_en_rb", got, 32'd1);

      // RX thresholds and ordering
      for (int i = 0; i < 7; i++) push(0, $urandom);
      @(negedge clk);
      chk("rx_single_7", rx_pri_single[0], 1'b1);
      chk("rx_burst_7", rx_pri_burst[0], 1'b0);
      push(0, $urandom);
      @(negedge clk); rx_pri_ack[0] = 1'b1;
      @(negedge clk); rx_pri_ack[0] = 1'b0;
      wait_sig("rx_rereq", 2, 1'b1, 3);
      chk("rx_burst_8", rx_pri_burst[0], 1'b1);
      for (int i = 0; i < 8; i++) pop_chk(0, "rx_pop_order");
      status_chk(0, "status_drained");

      // Overflow and interrupt
      ctrl_wr(0, 1, 1, 0, 0);
      for (int i = 0; i < 65; i++) push(0, $urandom);
      av_rd(0, 1, got); chk("ovf_status", got, 32'h0006_0040);
      chk("ovf_model", got, m_status(0));
      chk("ovf_irq", irq, 1'b1);
      ctrl_wr(0, 1, 1, 0, 1);
      wait_sig("irq_clear", 4, 1'b0, 2);
      av_rd(0, 2, got); chk("ctrl_errclr_rb", got, 32'd3);

      // Underflow on ch1, ch0 isolation
      pop_chk(1, "udf_rdata");
      av_rd(1, 1, got); chk("udf_status1", got, 32'h0009_0000);
      av_rd(0, 1, got); chk("iso_status0", got, 32'h0002_0040);
      chk("udf_no_irq", irq, 1'b0);

      // Clear while RX handshake is in HOLD
      chk("rx_pending", rx_pri_single[0], 1'b1);
      @(negedge clk); rx_pri_ack[0] = 1'b1;
      @(negedge clk);
      chk("rx_hold", rx_pri_single[0], 1'b0);
      ctrl_wr(0, 1, 1, 1, 0);
      status_chk(0, "clr_status");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("rx_hold_ack_hi", rx_pri_single[0], 1'b0);
      end
      rx_pri_ack[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("rx_no_rereq", rx_pri_single[0], 1'b0);
      end
      push(0, $urandom);
      wait_sig("rx_req_after_push", 2, 1'b1, 3);
      pop_chk(0, "clr_pop");

      // Randomised traffic against the queue model
      for (int it = 0; it < 300; it++) begin
         ch = $urandom_range(0, NCH - 1);
         op = $urandom_range(0, 99);
         if (op < 45) push(ch, $urandom);
         else if (op < 75) pop_chk(ch, "rnd_pop");
         else if (op < 85) status_chk(ch, "rnd_status");
         else if (op < 90) begin
            av_wr(ch, 3, $urandom);
            av_rd(ch, 3, got); chk("rnd_reg3", got, 32'd0);
         end else if (op < 97) ctrl_wr(ch, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
         else ctrl_wr(ch, 1'b1, 1'($urandom), 1'b1, 1'b0);
         @(negedge clk);
         chk("rnd_irq", irq, m_irq());
      end
      for (int c = 0; c < NCH; c++) status_chk(c, "final_status");

      // Asynchronous reset drops an active request immediately
      ctrl_wr(0, 1, 0, 1, 0);
      wait_sig("pre_reset_tx", 0, 1'b1, 3);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_rst_tx", tx_pri_single[0], 1'b0);
      chk("async_rst_irq", irq, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
